// File: rtl/ring_memory_responder.sv
// Single-port RAM responder serving the ring buffer's write/read request-done handshakes,
// round-robin arbitrated. Optional stored parity is enabled by defining MEMRESP_PARITY_EN.
module ring_memory_responder #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wreq,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic              wdone,
    input  logic              rreq,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rdone,
    output logic              perr
);

`ifdef MEMRESP_PARITY_EN
    localparam int RAM_W = DATA_W + 1;
`else
    localparam int RAM_W = DATA_W;
`endif
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    function automatic logic f_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    state_t            r_state;
    state_t            w_next;
    logic              w_grant;
    logic              w_grant_w;
    logic              r_op_w;
    logic              r_last_w;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_wdone;
    logic              r_rdone;
    logic [DATA_W-1:0] r_rdata;
    logic [RAM_W-1:0]  r_mem [DEPTH];
    logic [IDX_W-1:0]  w_idx;
    logic              w_in_range;
    logic              w_wr_en;
    logic [RAM_W-1:0]  w_wr_word;
    logic [RAM_W-1:0]  w_rd_word;

    always_comb begin
        w_next    = r_state;
        w_grant   = 1'b0;
        w_grant_w = 1'b0;
        case (r_state)
            S_IDLE: begin
                // On contention the side not served last time wins.
                if (wreq && rreq) begin
                    w_grant   = 1'b1;
                    w_grant_w = !r_last_w;
                end else if (wreq) begin
                    w_grant   = 1'b1;
                    w_grant_w = 1'b1;
                end else if (rreq) begin
                    w_grant   = 1'b1;
                    w_grant_w = 1'b0;
                end
                if (w_grant) begin
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_w <= 1'b0;
        end else if (r_state == S_IDLE && w_grant) begin
            r_op_w <= w_grant_w;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_grant) begin
            r_addr  <= w_grant_w ? waddr : raddr;
            r_wdata <= wdata;
        end
    end

    // Full-width compare: addresses beyond DEPTH never alias into the RAM.
    assign w_in_range = ({1'b0, r_addr} < LP_DEPTH);
    assign w_idx      = r_addr[IDX_W-1:0];
    assign w_wr_en    = (r_state == S_ACCESS) && r_op_w && w_in_range;
    assign w_rd_word  = r_mem[w_idx];

`ifdef MEMRESP_PARITY_EN
    assign w_wr_word = {f_parity(r_wdata), r_wdata};
`else
    assign w_wr_word = r_wdata;
`endif

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_idx] <= w_wr_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdone  <= 1'b0;
            r_rdone  <= 1'b0;
            r_rdata  <= '0;
            r_last_w <= 1'b0;
        end else begin
            r_wdone <= 1'b0;
            r_rdone <= 1'b0;
            if (r_state == S_ACCESS) begin
                r_last_w <= r_op_w;
                if (r_op_w) begin
                    r_wdone <= 1'b1;
                end else begin
                    r_rdone <= 1'b1;
                    r_rdata <= w_in_range ? w_rd_word[DATA_W-1:0] : '0;
                end
            end
        end
    end

`ifdef MEMRESP_PARITY_EN
    logic r_perr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= (r_state == S_ACCESS) && !r_op_w && w_in_range &&
                      (w_rd_word[DATA_W] != f_parity(w_rd_word[DATA_W-1:0]));
        end
    end

    assign perr = r_perr;
`else
    assign perr = 1'b0;
`endif

    assign wdone = r_wdone;
    assign rdone = r_rdone;
    assign rdata = r_rdata;

endmodule

// File: tb/tb_ring_memory_responder.sv
// Directed self-checking bench for ring_memory_responder: handshake latency, arbitration,
// out-of-range handling, reset abort and (with MEMRESP_PARITY_EN) parity error reporting.
module tb_ring_memory_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wreq = 1'b0;
    logic [15:0] waddr = '0;
    logic [15:0] wdata = '0;
    logic        wdone;
    logic        rreq = 1'b0;
    logic [15:0] raddr = '0;
    logic [15:0] rdata;
    logic        rdone;
    logic        perr;

    int n_checks = 0;
    int n_fail   = 0;

    ring_memory_responder #(
        .DATA_W(16),
        .ADDR_W(16),
        .DEPTH (256)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .wreq (wreq),
        .waddr(waddr),
        .wdata(wdata),
        .wdone(wdone),
        .rreq (rreq),
        .raddr(raddr),
        .rdata(rdata),
        .rdone(rdone),
        .perr (perr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one write and wait (bounded) for wdone; lat = cycles from request to done, -1 on timeout.
    task automatic do_write(input logic [15:0] a, input logic [15:0] d, output int lat);
        waddr = a;
        wdata = d;
        wreq  = 1'b1;
        lat   = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (wdone) begin
                lat = i;
                break;
            end
        end
        wreq = 1'b0;
        tick();
        chk("wdone_one_cycle", {31'd0, wdone}, 32'd0);
    endtask

    task automatic do_read(input logic [15:0] a, output logic [15:0] d,
                           output logic pe, output int lat);
        raddr = a;
        rreq  = 1'b1;
        lat   = -1;
        d     = '0;
        pe    = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (rdone) begin
                lat = i;
                d   = rdata;
                pe  = perr;
                break;
            end
        end
        rreq = 1'b0;
        tick();
        chk("rdone_one_cycle", {31'd0, rdone}, 32'd0);
    endtask

    initial begin
        int          lat;
        logic [15:0] d;
        logic        pe;
        logic        seen;

        // Reset values
        tick();
        chk("rst_wdone", {31'd0, wdone}, 32'd0);
        chk("rst_rdone", {31'd0, rdone}, 32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        chk("rst_perr",  {31'd0, perr},  32'd0);
        tick();
        rst = 1'b0;
        tick();

        // 1. Basic write: done two cycles after the request is sampled
        do_write(16'd3, 16'hA5C3, lat);
        chk("w3_latency", lat, 32'd2);

        // 2. Read back, then rdata must hold after rreq drops
        do_read(16'd3, d, pe, lat);
        chk("r3_latency", lat, 32'd2);
        chk("r3_data", {16'd0, d}, 32'h0000A5C3);
        chk("r3_perr", {31'd0, pe}, 32'd0);
        tick();
        tick();
        chk("r3_data_held", {16'd0, rdata}, 32'h0000A5C3);

        // 3. Simultaneous requests: write wins first, read completes three cycles later
        waddr = 16'd5;
        wdata = 16'h1111;
        raddr = 16'd5;
        wreq  = 1'b1;
        rreq  = 1'b1;
        tick();
        tick();
        chk("dual_first_done", {30'd0, wdone, rdone}, 32'b10);
        wreq = 1'b0;
        tick();
        chk("dual_gap1", {30'd0, wdone, rdone}, 32'b00);
        tick();
        chk("dual_gap2", {30'd0, wdone, rdone}, 32'b00);
        tick();
        chk("dual_second_done", {30'd0, wdone, rdone}, 32'b01);
        chk("dual_rdata", {16'd0, rdata}, 32'h00001111);
        rreq = 1'b0;
        tick();

        // Sustained contention: grants alternate W,R,W,R starting with W (last grant was R)
        waddr = 16'd7;
        wdata = 16'h7777;
        raddr = 16'd5;
        wreq  = 1'b1;
        rreq  = 1'b1;
        for (int g = 0; g < 4; g++) begin
            tick();
            tick();
            chk($sformatf("alt_grant%0d", g), {30'd0, wdone, rdone},
                (g % 2 == 0) ? 32'b10 : 32'b01);
            tick();
        end
        wreq = 1'b0;
        rreq = 1'b0;
        chk("alt_rdata", {16'd0, rdata}, 32'h00001111);
        tick();
        do_read(16'd7, d, pe, lat);
        chk("alt_w7_landed", {16'd0, d}, 32'h00007777);

        // 4. Out-of-range accesses and no address wrap
        do_write(16'd0, 16'h0BEE, lat);
        do_write(16'd256, 16'hFFFF, lat);
        chk("oor_wdone_latency", lat, 32'd2);
        do_read(16'd256, d, pe, lat);
        chk("oor_rdone_latency", lat, 32'd2);
        chk("oor_rdata_zero", {16'd0, d}, 32'd0);
        chk("oor_perr", {31'd0, pe}, 32'd0);
        do_read(16'd0, d, pe, lat);
        chk("word0_unchanged", {16'd0, d}, 32'h00000BEE);
        do_write(16'h0103, 16'h1234, lat);
        do_read(16'd3, d, pe, lat);
        chk("no_wrap_addr3", {16'd0, d}, 32'h0000A5C3);

        // 5. Reset while a read is in ACCESS
        raddr = 16'd5;
        rreq  = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        chk("abort_rdata_zero", {16'd0, rdata}, 32'd0);
        rreq = 1'b0;
        seen = 1'b0;
        tick();
        seen = seen | rdone;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | rdone;
        end
        chk("abort_no_rdone", {31'd0, seen}, 32'd0);
        do_read(16'd3, d, pe, lat);
        chk("post_abort_read", {16'd0, d}, 32'h0000A5C3);
        chk("post_abort_latency", lat, 32'd2);

        // 6. Parity error reporting
        do_write(16'd1, 16'h0001, lat);
`ifdef MEMRESP_PARITY_EN
        force dut.r_mem[1][16] = 1'b0;
        do_read(16'd1, d, pe, lat);
        chk("par_rdata", {16'd0, d}, 32'h00000001);
        chk("par_perr_at_done", {31'd0, pe}, 32'd1);
        chk("par_perr_after", {31'd0, perr}, 32'd0);
        release dut.r_mem[1][16];
`else
        do_read(16'd1, d, pe, lat);
        chk("par_rdata", {16'd0, d}, 32'h00000001);
        chk("par_perr_tied", {31'd0, pe}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
